// File: rtl/systolic_pkg.sv
// Shared constants and reader FSM state encoding for the systolic array output path.
package systolic_pkg;
  localparam int ACC_BWIDTH             = 32;
  localparam int PE_ARRAY_NUM_COLS      = 32;
  localparam int PE_ARRAY_NUM_COLS_LOG2 = 5;
  localparam int OUT_SRAM_AWIDTH        = 10;
  localparam int OUT_SRAM_BWIDTH        = ACC_BWIDTH * PE_ARRAY_NUM_COLS;
  localparam int NW_W                   = PE_ARRAY_NUM_COLS_LOG2 + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_STREAM, ST_FIN} rd_state_t;
endpackage

// File: rtl/out_row_serializer.sv
// Row buffer(s), word index, lane mux and valid/ready handshake for out_sram_reader.
// OUT_SRAM_READER_PREFETCH_EN selects a two-entry row buffer ring.
module out_row_serializer
  import systolic_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       load,
  input  logic [OUT_SRAM_BWIDTH-1:0] row_d,
  input  logic                       active,
  input  logic                       ready,
  input  logic                       stall,
  input  logic [NW_W-1:0]            num_words,
  output logic                       valid,
  output logic [ACC_BWIDTH-1:0]      data,
  output logic                       last_word,
  output logic                       row_done
`ifdef OUT_SRAM_READER_PREFETCH_EN
  ,
  output logic [1:0]                 fill
`endif
);
  logic [PE_ARRAY_NUM_COLS_LOG2-1:0] word_idx;
  logic [NW_W-1:0]                   last_idx;
  logic                              xfer, idx_clr;

  assign last_idx  = num_words - 1'b1;
  assign last_word = valid && ({1'b0, word_idx} == last_idx);
  assign xfer      = valid && ready && !stall;
  assign row_done  = xfer && last_word;

`ifdef OUT_SRAM_READER_PREFETCH_EN
  logic [1:0][OUT_SRAM_BWIDTH-1:0] row_buf;
  logic                            wr_sel, rd_sel;
  logic [1:0]                      cnt;

  // A load may land mid-row into the idle entry, so it must not touch word_idx.
  assign idx_clr = 1'b0;
  assign valid   = active && (cnt != 2'd0);
  assign data    = row_buf[rd_sel][word_idx*ACC_BWIDTH +: ACC_BWIDTH];
  assign fill    = cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_buf <= '0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (load) begin
        row_buf[wr_sel] <= row_d;
        wr_sel          <= ~wr_sel;
      end
      if (row_done) rd_sel <= ~rd_sel;
      cnt <= cnt + {1'b0, load} - {1'b0, row_done};
    end
  end
`else
  logic [OUT_SRAM_BWIDTH-1:0] row_buf;

  assign idx_clr = load;
  assign valid   = active;
  assign data    = row_buf[word_idx*ACC_BWIDTH +: ACC_BWIDTH];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)     row_buf <= '0;
    else if (load) row_buf <= row_d;
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                   word_idx <= '0;
    else if (row_done || idx_clr) word_idx <= '0;
    else if (xfer)               word_idx <= word_idx + 1'b1;
  end
endmodule

// File: rtl/out_sram_reader.sv
// Drains output SRAM rows after a tile and streams them as ACC_BWIDTH words.
// Define OUT_SRAM_READER_PREFETCH_EN to overlap the next row read with streaming.
module out_sram_reader
  import systolic_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       START,
  input  logic                       STALL,
  input  logic [OUT_SRAM_AWIDTH-1:0] BASE_ADDR_in,
  input  logic [OUT_SRAM_AWIDTH:0]   NUM_ROWS_in,
  input  logic [NW_W-1:0]            NUM_WORDS_in,
  output logic [OUT_SRAM_AWIDTH-1:0] SRAM_ADDR_out,
  output logic                       SRAM_CSn_out,
  output logic                       SRAM_WEn_out,
  input  logic [OUT_SRAM_BWIDTH-1:0] SRAM_D_in,
  output logic                       OUT_VALID_out,
  input  logic                       OUT_READY_in,
  output logic [ACC_BWIDTH-1:0]      OUT_DATA_out,
  output logic                       OUT_LAST_out,
  output logic                       BUSY_out,
  output logic                       DONE_out
);
  rd_state_t                  state, nstate;
  logic [OUT_SRAM_AWIDTH-1:0] base;
  logic [OUT_SRAM_AWIDTH:0]   nrows, row_idx;
  logic [NW_W-1:0]            nw;
  logic                       load, active, csn, valid, last_word, row_done, last_row, start_ok;

  assign start_ok = (state == ST_IDLE) && START;
  assign last_row = (row_idx + 1'b1) == nrows;

`ifdef OUT_SRAM_READER_PREFETCH_EN
  localparam rd_state_t ST_ROW = ST_STREAM;
  logic [OUT_SRAM_AWIDTH:0] rd_idx;
  logic                     pend, issue;
  logic [1:0]               fill;
  logic [2:0]               occ;

  // Issue when a buffer entry will be free by the time the data lands.
  assign occ   = {1'b0, fill} + {2'b0, pend};
  assign issue = (state == ST_STREAM) && !STALL && (rd_idx != nrows) &&
                 ((occ < 3'd2) || (row_done && (occ < 3'd3)));
  assign SRAM_ADDR_out = base + rd_idx[OUT_SRAM_AWIDTH-1:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_idx <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= issue;
      if (start_ok)   rd_idx <= '0;
      else if (issue) rd_idx <= rd_idx + 1'b1;
    end
  end
`else
  localparam rd_state_t ST_ROW = ST_RD;
  assign SRAM_ADDR_out = base + row_idx[OUT_SRAM_AWIDTH-1:0];
`endif

  always_comb begin
    nstate = state;
    csn    = 1'b1;
    load   = 1'b0;
    active = 1'b0;
    case (state)
      ST_IDLE:   if (START) nstate = (NUM_ROWS_in == '0) ? ST_FIN : ST_ROW;
      ST_RD:     if (!STALL) begin
                   csn    = 1'b0;
                   nstate = ST_CAP;
                 end
      ST_CAP:    begin
                   load   = 1'b1;
                   nstate = ST_STREAM;
                 end
      ST_STREAM: begin
                   active = 1'b1;
`ifdef OUT_SRAM_READER_PREFETCH_EN
                   csn    = ~issue;
                   load   = pend;
`endif
                   if (row_done) nstate = last_row ? ST_FIN : ST_ROW;
                 end
      ST_FIN:    nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= ST_IDLE;
      base    <= '0;
      nrows   <= '0;
      nw      <= '0;
      row_idx <= '0;
    end else begin
      state <= nstate;
      if (start_ok) begin
        base    <= BASE_ADDR_in;
        nrows   <= NUM_ROWS_in;
        nw      <= (NUM_WORDS_in == '0) ? NW_W'(PE_ARRAY_NUM_COLS) : NUM_WORDS_in;
        row_idx <= '0;
      end else if (row_done) begin
        row_idx <= row_idx + 1'b1;
      end
    end
  end

  out_row_serializer u_ser (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .load      (load),
    .row_d     (SRAM_D_in),
    .active    (active),
    .ready     (OUT_READY_in),
    .stall     (STALL),
    .num_words (nw),
    .valid     (valid),
    .data      (OUT_DATA_out),
    .last_word (last_word),
    .row_done  (row_done)
`ifdef OUT_SRAM_READER_PREFETCH_EN
    ,
    .fill      (fill)
`endif
  );

  assign SRAM_CSn_out  = csn;
  assign SRAM_WEn_out  = 1'b1;
  assign OUT_VALID_out = valid;
  assign OUT_LAST_out  = last_word && last_row;
  assign BUSY_out      = (state != ST_IDLE);
  assign DONE_out      = (state == ST_FIN);
endmodule

// File: tb/tb_out_sram_reader.sv
// Scoreboard bench for out_sram_reader: expected words/addresses queued at stimulus,
// checked by a negedge monitor against an SRAM whose lane j of row a holds a*100+j.
module tb_out_sram_reader;
  import systolic_pkg::*;

  logic CLK = 1'b0, RSTn = 1'b0, START = 1'b0, STALL = 1'b0, OUT_READY_in = 1'b0;
  logic [9:0]    BASE_ADDR_in = '0;
  logic [10:0]   NUM_ROWS_in  = '0;
  logic [5:0]    NUM_WORDS_in = '0;
  logic [1023:0] SRAM_D_in    = '0;
  logic [9:0]    SRAM_ADDR_out;
  logic [31:0]   OUT_DATA_out;
  logic SRAM_CSn_out, SRAM_WEn_out, OUT_VALID_out, OUT_LAST_out, BUSY_out, DONE_out;

  out_sram_reader dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .STALL(STALL),
    .BASE_ADDR_in(BASE_ADDR_in), .NUM_ROWS_in(NUM_ROWS_in), .NUM_WORDS_in(NUM_WORDS_in),
    .SRAM_ADDR_out(SRAM_ADDR_out), .SRAM_CSn_out(SRAM_CSn_out), .SRAM_WEn_out(SRAM_WEn_out),
    .SRAM_D_in(SRAM_D_in), .OUT_VALID_out(OUT_VALID_out), .OUT_READY_in(OUT_READY_in),
    .OUT_DATA_out(OUT_DATA_out), .OUT_LAST_out(OUT_LAST_out),
    .BUSY_out(BUSY_out), .DONE_out(DONE_out)
  );

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, last_cyc = 0;
  bit rand_en = 1'b0, last_seen = 1'b0;
  logic [32:0] exp_q[$];
  logic [9:0]  addr_q[$];
  int          xcyc_q[$];

  function automatic logic [31:0] mem_word(input int a, input int j);
    return a * 100 + j;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not reached", nm);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK)
    if (!SRAM_CSn_out)
      for (int j = 0; j < 32; j++) SRAM_D_in[j*32 +: 32] <= mem_word(int'(SRAM_ADDR_out), j);

  initial forever begin
    @(posedge CLK); #1;
    if (rand_en) OUT_READY_in = 1'($urandom_range(0, 1));
  end

  // Monitor: addresses, words, hold rules while not taken, DONE placement.
  logic        pv = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge CLK) begin
    logic [32:0] e;
    if (!RSTn) begin
      pv = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (pv) begin
        chk("hold_valid", OUT_VALID_out, 1);
        chk("hold_data", OUT_DATA_out, pd);
      end
      if (STALL) chk("stall_csn", SRAM_CSn_out, 1);
      if (!SRAM_CSn_out) begin
        if (addr_q.size() == 0) fail("unexpected_read");
        else chk("sram_addr", SRAM_ADDR_out, addr_q.pop_front());
      end
      if (OUT_VALID_out && OUT_READY_in && !STALL) begin
        xcyc_q.push_back(cyc);
        if (exp_q.size() == 0) fail("unexpected_word");
        else begin
          e = exp_q.pop_front();
          chk("data", OUT_DATA_out, e[31:0]);
          chk("last", OUT_LAST_out, e[32]);
        end
        if (OUT_LAST_out) begin
          last_seen = 1'b1;
          last_cyc  = cyc;
        end
        pv = 1'b0;
      end else begin
        pv = OUT_VALID_out;
        pd = OUT_DATA_out;
      end
      if (DONE_out) begin
        done_cnt++;
        if (last_seen) chk("done_after_last", cyc - last_cyc, 1);
        last_seen = 1'b0;
        chk("done_words_left", exp_q.size(), 0);
        chk("done_reads_left", addr_q.size(), 0);
      end
    end
  end

  // Reference model: rows base..base+rows-1 mod 1024, lanes 0..nw-1, LAST on the final one.
  task automatic expect_xfer(input int b, input int rows, input int words);
    int nw, a;
    logic lb;
    nw = (words == 0) ? 32 : words;
    for (int r = 0; r < rows; r++) begin
      a = (b + r) % 1024;
      addr_q.push_back(10'(a));
      for (int w = 0; w < nw; w++) begin
        lb = (r == rows - 1) && (w == nw - 1);
        exp_q.push_back({lb, mem_word(a, w)});
      end
    end
  endtask

  task automatic go(input int b, input int rows, input int words);
    BASE_ADDR_in = 10'(b);
    NUM_ROWS_in  = 11'(rows);
    NUM_WORDS_in = 6'(words);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input string nm);
    int i;
    for (i = 0; i < 6000; i++) begin
      @(posedge CLK);
      if (done_cnt >= tgt) break;
    end
    #1;
    if (i == 6000) fail(nm);
  endtask

  task automatic wait_words(input int n, input string nm);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(posedge CLK);
      if (xcyc_q.size() >= n) break;
    end
    #2;
    if (i == 2000) fail(nm);
  endtask

  initial begin
    int tgt, lat, n0;
    @(negedge CLK);
    chk("rst_valid", OUT_VALID_out, 0);
    chk("rst_csn", SRAM_CSn_out, 1);
    chk("rst_wen", SRAM_WEn_out, 1);
    chk("rst_busy", BUSY_out, 0);
    chk("rst_done", DONE_out, 0);
    chk("rst_last", OUT_LAST_out, 0);
    chk("rst_addr", SRAM_ADDR_out, 0);
    chk("rst_data", OUT_DATA_out, 0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    OUT_READY_in = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Basic drain with latency and row-gap checks.
    expect_xfer(0, 2, 32);
    xcyc_q.delete();
    tgt = done_cnt + 1;
    go(0, 2, 32);
    @(negedge CLK); chk("lat_rd_valid", OUT_VALID_out, 0); chk("lat_busy", BUSY_out, 1);
    @(negedge CLK); chk("lat_cap_valid", OUT_VALID_out, 0);
    @(negedge CLK); chk("lat_stream_valid", OUT_VALID_out, 1);
    wait_done(tgt, "basic_timeout");
    chk("basic_count", xcyc_q.size(), 64);
    if (xcyc_q.size() > 0)
`ifdef OUT_SRAM_READER_PREFETCH_EN
      chk("basic_span", xcyc_q[$] - xcyc_q[0] + 1, 64);
`else
      chk("basic_span", xcyc_q[$] - xcyc_q[0] + 1, 66);
`endif

    // Partial row with address wrap.
    expect_xfer(1023, 2, 5);
    tgt = done_cnt + 1;
    go(1023, 2, 5);
    wait_done(tgt, "wrap_timeout");

    // Random transfers under random backpressure.
    rand_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int b, r, w;
      b = $urandom_range(0, 1023);
      r = $urandom_range(1, 4);
      w = $urandom_range(0, 32);
      expect_xfer(b, r, w);
      tgt = done_cnt + 1;
      go(b, r, w);
      wait_done(tgt, "random_timeout");
    end
    rand_en = 1'b0;
    @(posedge CLK); #1;
    OUT_READY_in = 1'b1;

    // Zero rows.
    tgt = done_cnt + 1;
    go(7, 0, 4);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK);
      if (done_cnt >= tgt && lat == 0) lat = i;
    end
    #1;
    chk("zero_rows_done_latency_ok", (lat >= 1 && lat <= 2), 1);

    // START while busy is ignored.
    expect_xfer(5, 2, 32);
    tgt = done_cnt + 1;
    go(5, 2, 32);
    repeat (10) @(posedge CLK);
    #1;
    go(200, 3, 7);
    wait_done(tgt, "busy_start_timeout");
    repeat (20) @(posedge CLK);
    #1;
    chk("busy_start_done_count", done_cnt, tgt);
    chk("busy_start_no_tail", exp_q.size(), 0);

    // STALL during RD and during STREAM.
    expect_xfer(300, 2, 8);
    tgt = done_cnt + 1;
    go(300, 2, 8);
    STALL = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    STALL = 1'b0;
    n0 = xcyc_q.size();
    wait_words(n0 + 3, "stall_words_timeout");
    STALL = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    STALL = 1'b0;
    wait_done(tgt, "stall_timeout");

    // Reset mid-transfer, then restart from BASE.
    expect_xfer(40, 2, 32);
    n0 = xcyc_q.size();
    go(40, 2, 32);
    wait_words(n0 + 7, "rst_words_timeout");
    RSTn = 1'b0;
    #1;
    chk("midrst_valid", OUT_VALID_out, 0);
    chk("midrst_busy", BUSY_out, 0);
    chk("midrst_done", DONE_out, 0);
    exp_q.delete();
    addr_q.delete();
    tgt = done_cnt;
    repeat (3) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("midrst_no_done", done_cnt, tgt);
    expect_xfer(40, 1, 6);
    tgt = done_cnt + 1;
    go(40, 1, 6);
    wait_done(tgt, "restart_timeout");

`ifdef OUT_SRAM_READER_PREFETCH_EN
    expect_xfer(0, 4, 32);
    xcyc_q.delete();
    tgt = done_cnt + 1;
    go(0, 4, 32);
    wait_done(tgt, "prefetch_timeout");
    chk("prefetch_count", xcyc_q.size(), 128);
    if (xcyc_q.size() > 0) chk("prefetch_span", xcyc_q[$] - xcyc_q[0] + 1, 128);
`endif

    repeat (4) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
